// File: rtl/uart_tx_engine.sv
// Serial transmitter: start bit, DATA_WIDTH payload bits LSB first, optional parity, stop bit.
// Back-to-back frames are supported by accepting a new request during the stop bit.
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Gray sequence: adjacent states along the frame path differ in one bit
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b010,
    STOP   = 3'b110
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;

  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_parity;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_parity  = (^r_data) ^ r_par_typ;

  // Outputs are loaded together with the next state so TX_OUT/Busy come straight from flops
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (DATA_VALID) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_state   <= START;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
          end else begin
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
          end
        end
        START: begin
          r_cnt   <= '0;
          r_state <= DATA;
          TX_OUT  <= r_data[0];
          Busy    <= 1'b1;
        end
        DATA: begin
          Busy <= 1'b1;
          if (r_cnt == LAST_BIT) begin
            r_cnt <= '0;
            if (r_par_en) begin
              r_state <= PARITY;
              TX_OUT  <= w_parity;
            end else begin
              r_state <= STOP;
              TX_OUT  <= 1'b1;
            end
          end else begin
            r_cnt  <= w_cnt_inc;
            TX_OUT <= r_data[w_cnt_inc];
          end
        end
        PARITY: begin
          r_state <= STOP;
          TX_OUT  <= 1'b1;
          Busy    <= 1'b1;
        end
        STOP: begin
          // A request seen on the last stop-bit edge chains directly into the next start bit
          if (DATA_VALID) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_state   <= START;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
          end else begin
            r_state   <= IDLE;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          TX_OUT  <= 1'b1;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: expected serial frames are hand-written bit strings,
// first character = start bit, last character = stop bit.
module tb_uart_tx_engine;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  uart_tx_engine #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks the frame starting at the current cycle; ends one cycle after the stop bit.
  // pert_at >= 0 disturbs all inputs after that cycle and raises DATA_VALID for one cycle.
  task automatic check_frame(input string tag, input string seq, input int pert_at);
    for (int i = 0; i < seq.len(); i++) begin
      chk($sformatf("%s_tx[%0d]", tag, i), TX_OUT, (seq[i] == "1"));
      chk($sformatf("%s_busy[%0d]", tag, i), Busy, 1'b1);
      if (i == pert_at) begin
        DATA_VALID = 1'b1;
        P_DATA     = ~P_DATA;
        PAR_EN     = ~PAR_EN;
        PAR_TYP    = ~PAR_TYP;
      end
      if (pert_at >= 0 && i == pert_at + 1) DATA_VALID = 1'b0;
      step();
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_tx[%0d]", tag, i), TX_OUT, 1'b1);
      chk($sformatf("%s_busy[%0d]", tag, i), Busy, 1'b0);
      step();
    end
  endtask

  initial begin
    RST        = 1'b0;
    DATA_VALID = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    step();
    step();
    chk("reset_tx", TX_OUT, 1'b1);
    chk("reset_busy", Busy, 1'b0);
    RST = 1'b1;

    check_idle("idle20", 20);

    // 0xA5 without parity
    P_DATA = 8'hA5; PAR_EN = 1'b0; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    check_frame("a5_nopar", "0101001011", -1);
    check_idle("post_a5", 3);

    // 0xA5 even parity (four ones -> 0)
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    check_frame("a5_even", "01010010101", -1);
    check_idle("post_even", 2);

    // 0xA5 odd parity -> 1
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    check_frame("a5_odd", "01010010111", -1);
    check_idle("post_odd", 2);

    // Back-to-back: 0x01 then 0xFF with DATA_VALID held high
    P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    step();
    P_DATA = 8'hFF;
    check_frame("b2b_f1", "0100000001", -1);
    DATA_VALID = 1'b0;
    check_frame("b2b_f2", "0111111111", -1);
    check_idle("post_b2b", 3);

    // Inputs disturbed mid-frame must not alter the frame or queue another
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    check_frame("perturb", "01010010101", 3);
    check_idle("no_extra", 5);

    // Asynchronous reset during data bit 3 of 0x00
    P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pre_rst_tx[%0d]", i), TX_OUT, 1'b0);
      step();
    end
    chk("pre_rst_bit3_tx", TX_OUT, 1'b0);
    chk("pre_rst_bit3_busy", Busy, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    chk("rst_async_tx", TX_OUT, 1'b1);
    chk("rst_async_busy", Busy, 1'b0);
    step();
    chk("rst_hold_tx", TX_OUT, 1'b1);
    chk("rst_hold_busy", Busy, 1'b0);
    RST = 1'b1;
    check_idle("post_rst", 2);

    // Fresh frame after reset: 0x3C
    P_DATA = 8'h3C; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    check_frame("after_rst", "0001111001", -1);
    check_idle("end", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
